// File: rtl/m_rep_flit_fifo.sv
// Reply flit FIFO: buffers {ctrl, flit} pairs from the uploader and shows the head to the arbiter.
// Latency: a push into an empty FIFO appears on flit_out one cycle later.
// Backpressure: rep_fifo_rdy drops only at full and comes from registered occupancy, not from pop.
module m_rep_flit_fifo #(
    parameter int FW    = 16,
    parameter int DEPTH = 16,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [FW-1:0] flit_in,
    input  logic          v_flit_in,
    input  logic [1:0]    ctrl_in,
    output logic          rep_fifo_rdy,
    output logic [FW-1:0] flit_out,
    output logic [1:0]    ctrl_out,
    output logic          v_flit_out,
    input  logic          pop,
    output logic          msg_avail,
    output logic [AW:0]   occupancy
);

    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
    localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
    localparam logic [1:0]    CTRL_TAIL = 2'b11;

    // Each entry holds {ctrl, flit}; contents are deliberately left unreset.
    logic [FW+1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   occ_q;
    logic [AW:0]   msg_cnt;
    logic [FW+1:0] head_word;
    logic          push;
    logic          pop_eff;
    logic          push_tail;
    logic          pop_tail;

    assign rep_fifo_rdy = (occ_q != FULL_CNT);
    assign v_flit_out   = (occ_q != '0);
    assign occupancy    = occ_q;
    assign msg_avail    = (msg_cnt != '0);

    // Gate the show-ahead read so stale or never-written storage reads as zero while empty.
    assign head_word = mem[rd_ptr];
    assign flit_out  = v_flit_out ? head_word[FW-1:0]     : '0;
    assign ctrl_out  = v_flit_out ? head_word[FW+1:FW]    : 2'b00;

    assign push      = v_flit_in & rep_fifo_rdy;
    assign pop_eff   = pop & v_flit_out;
    assign push_tail = push & (ctrl_in == CTRL_TAIL);
    assign pop_tail  = pop_eff & (ctrl_out == CTRL_TAIL);

    // Storage write; no reset so it maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {ctrl_in, flit_in};
        end
    end

    // Read/write pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push)    wr_ptr <= wr_ptr + PTR_ONE;
            if (pop_eff) rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // Flit count: a simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            occ_q <= '0;
        end else if (push && !pop_eff) begin
            occ_q <= occ_q + CNT_ONE;
        end else if (!push && pop_eff) begin
            occ_q <= occ_q - CNT_ONE;
        end
    end

    // Complete-message count, stepped by tails entering and leaving.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            msg_cnt <= '0;
        end else if (push_tail && !pop_tail) begin
            msg_cnt <= msg_cnt + CNT_ONE;
        end else if (!push_tail && pop_tail) begin
            msg_cnt <= msg_cnt - CNT_ONE;
        end
    end

`ifndef SYNTHESIS
    a_msg_le_occ: assert property (@(posedge clk) disable iff (!rst) msg_cnt <= occ_q);
    a_no_ovf:     assert property (@(posedge clk) disable iff (!rst) !(push && occ_q == FULL_CNT));
    a_no_udf:     assert property (@(posedge clk) disable iff (!rst) !(pop_eff && occ_q == '0));
`endif

endmodule

// File: tb/tb_m_rep_flit_fifo.sv
module tb_m_rep_flit_fifo;

    localparam int FW    = 16;
    localparam int DEPTH = 16;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [FW-1:0] flit_in;
    logic          v_flit_in;
    logic [1:0]    ctrl_in;
    logic          rep_fifo_rdy;
    logic [FW-1:0] flit_out;
    logic [1:0]    ctrl_out;
    logic          v_flit_out;
    logic          pop;
    logic          msg_avail;
    logic [AW:0]   occupancy;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model: FIFO of {ctrl, flit} words in arrival order.
    logic [17:0] mq[$];

    m_rep_flit_fifo #(.FW(FW), .DEPTH(DEPTH), .AW(AW)) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_in      (flit_in),
        .v_flit_in    (v_flit_in),
        .ctrl_in      (ctrl_in),
        .rep_fifo_rdy (rep_fifo_rdy),
        .flit_out     (flit_out),
        .ctrl_out     (ctrl_out),
        .v_flit_out   (v_flit_out),
        .pop          (pop),
        .msg_avail    (msg_avail),
        .occupancy    (occupancy)
    );

    always #5 clk = ~clk;

    function automatic int model_msgs();
        int n = 0;
        foreach (mq[i]) if (mq[i][17:16] == 2'b11) n++;
        return n;
    endfunction

    // Advance one clock, updating the model from the inputs presented this cycle.
    task automatic step(output bit pushed);
        bit p, q;
        p = v_flit_in && (mq.size() < DEPTH);
        q = pop && (mq.size() > 0);
        @(posedge clk);
        if (q) void'(mq.pop_front());
        if (p) mq.push_back({ctrl_in, flit_in});
        pushed = p;
        #1;
    endtask

    task automatic idle_inputs();
        v_flit_in = 1'b0;
        pop       = 1'b0;
        flit_in   = '0;
        ctrl_in   = 2'b00;
    endtask

    task automatic drain();
        bit d;
        pop = 1'b1;
        for (int i = 0; i < DEPTH + 2; i++) step(d);
        pop = 1'b0;
    endtask

    task automatic test_reset();
        bit d;
        // Power-on reset.
        rst = 1'b0;
        idle_inputs();
        #2;
        n_chk++; if (rep_fifo_rdy !== 1'b1) $display("FAIL por_rdy got %b want 1", rep_fifo_rdy); else n_pass++;
        n_chk++; if (v_flit_out !== 1'b0) $display("FAIL por_vld got %b want 0", v_flit_out); else n_pass++;
        n_chk++; if (occupancy !== 5'd0) $display("FAIL por_occ got %0d want 0", occupancy); else n_pass++;
        #1 rst = 1'b1;
        // Reset in the middle of a partially buffered message.
        v_flit_in = 1'b1; ctrl_in = 2'b01; flit_in = 16'h1111; step(d);
        ctrl_in = 2'b11; flit_in = 16'h2222; step(d);
        ctrl_in = 2'b01; flit_in = 16'h3333; step(d);
        v_flit_in = 1'b0;
        n_chk++; if (occupancy !== 5'd3) $display("FAIL pre_rst_occ got %0d want 3", occupancy); else n_pass++;
        #3 rst = 1'b0;
        #1;
        n_chk++; if (rep_fifo_rdy !== 1'b1) $display("FAIL rst_rdy got %b want 1", rep_fifo_rdy); else n_pass++;
        n_chk++; if (v_flit_out !== 1'b0) $display("FAIL rst_vld got %b want 0", v_flit_out); else n_pass++;
        n_chk++; if (occupancy !== 5'd0) $display("FAIL rst_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (msg_avail !== 1'b0) $display("FAIL rst_msg got %b want 0", msg_avail); else n_pass++;
        n_chk++; if (flit_out !== 16'h0 || ctrl_out !== 2'b00)
            $display("FAIL rst_head got %h/%b want 0000/00", flit_out, ctrl_out); else n_pass++;
        #1 rst = 1'b1;
        mq.delete();
    endtask

    task automatic test_single_msg();
        bit d;
        v_flit_in = 1'b1; flit_in = 16'hc0de; ctrl_in = 2'b11; step(d);
        v_flit_in = 1'b0;
        n_chk++; if (v_flit_out !== 1'b1) $display("FAIL single_vld got %b want 1", v_flit_out); else n_pass++;
        n_chk++; if (flit_out !== 16'hc0de) $display("FAIL single_flit got %h want c0de", flit_out); else n_pass++;
        n_chk++; if (msg_avail !== 1'b1) $display("FAIL single_msg got %b want 1", msg_avail); else n_pass++;
        pop = 1'b1; step(d); pop = 1'b0;
        n_chk++; if (occupancy !== 5'd0) $display("FAIL single_pop_occ got %0d want 0", occupancy); else n_pass++;
        n_chk++; if (msg_avail !== 1'b0) $display("FAIL single_pop_msg got %b want 0", msg_avail); else n_pass++;
    endtask

    task automatic test_multi_flit();
        bit d;
        logic [15:0] exp_f[3];
        logic [1:0]  exp_c[3];
        exp_f[0] = 16'habc1; exp_f[1] = 16'habc2; exp_f[2] = 16'habc3;
        exp_c[0] = 2'b01;    exp_c[1] = 2'b10;    exp_c[2] = 2'b11;
        v_flit_in = 1'b1;
        for (int i = 0; i < 3; i++) begin
            flit_in = exp_f[i]; ctrl_in = exp_c[i]; step(d);
            if (i == 1) begin
                n_chk++; if (msg_avail !== 1'b0) $display("FAIL multi_partial_msg got %b want 0", msg_avail); else n_pass++;
            end
        end
        v_flit_in = 1'b0;
        n_chk++; if (msg_avail !== 1'b1) $display("FAIL multi_full_msg got %b want 1", msg_avail); else n_pass++;
        pop = 1'b1;
        for (int i = 0; i < 3; i++) begin
            n_chk++; if (flit_out !== exp_f[i] || ctrl_out !== exp_c[i])
                $display("FAIL multi_order[%0d] got %h/%b want %h/%b", i, flit_out, ctrl_out, exp_f[i], exp_c[i]);
            else n_pass++;
            step(d);
        end
        pop = 1'b0;
        n_chk++; if (v_flit_out !== 1'b0) $display("FAIL multi_empty got %b want 0", v_flit_out); else n_pass++;
    endtask

    task automatic test_fill_wrap();
        bit d;
        logic [15:0] data[DEPTH+1];
        // Offset the pointers first so the fill crosses the wrap point.
        v_flit_in = 1'b1; ctrl_in = 2'b10;
        for (int i = 0; i < 5; i++) begin flit_in = 16'(i); step(d); end
        v_flit_in = 1'b0; drain();
        for (int i = 0; i <= DEPTH; i++) data[i] = 16'($urandom);
        v_flit_in = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            flit_in = data[i]; ctrl_in = (i == DEPTH-1) ? 2'b11 : 2'b10; step(d);
        end
        n_chk++; if (rep_fifo_rdy !== 1'b0) $display("FAIL fill_rdy got %b want 0", rep_fifo_rdy); else n_pass++;
        n_chk++; if (occupancy !== 5'd16) $display("FAIL fill_occ got %0d want 16", occupancy); else n_pass++;
        // A 17th flit held valid is not stored, even with a pop in the same cycle.
        flit_in = data[DEPTH]; ctrl_in = 2'b11; step(d);
        n_chk++; if (occupancy !== 5'd16) $display("FAIL fill_hold_occ got %0d want 16", occupancy); else n_pass++;
        pop = 1'b1; step(d); pop = 1'b0;
        n_chk++; if (rep_fifo_rdy !== 1'b1 || occupancy !== 5'd15)
            $display("FAIL fill_free got rdy=%b occ=%0d want rdy=1 occ=15", rep_fifo_rdy, occupancy); else n_pass++;
        step(d); v_flit_in = 1'b0;
        n_chk++; if (occupancy !== 5'd16) $display("FAIL fill_accept_occ got %0d want 16", occupancy); else n_pass++;
        pop = 1'b1;
        for (int i = 1; i <= DEPTH; i++) begin
            n_chk++; if (flit_out !== data[i]) $display("FAIL fill_order[%0d] got %h want %h", i, flit_out, data[i]);
            else n_pass++;
            step(d);
        end
        pop = 1'b0;
        n_chk++; if (occupancy !== 5'd0) $display("FAIL fill_drain_occ got %0d want 0", occupancy); else n_pass++;
    endtask

    task automatic test_simultaneous();
        bit d;
        v_flit_in = 1'b1; ctrl_in = 2'b10;
        for (int i = 0; i < 5; i++) begin flit_in = 16'h5000 + 16'(i); step(d); end
        n_chk++; if (msg_avail !== 1'b0) $display("FAIL simul_pre_msg got %b want 0", msg_avail); else n_pass++;
        flit_in = 16'h5fff; ctrl_in = 2'b11; pop = 1'b1; step(d);
        v_flit_in = 1'b0; pop = 1'b0;
        n_chk++; if (occupancy !== 5'd5) $display("FAIL simul_occ got %0d want 5", occupancy); else n_pass++;
        n_chk++; if (msg_avail !== 1'b1) $display("FAIL simul_msg got %b want 1", msg_avail); else n_pass++;
        n_chk++; if (flit_out !== 16'h5001) $display("FAIL simul_head got %h want 5001", flit_out); else n_pass++;
        drain();
        v_flit_in = 1'b1; flit_in = 16'h7777; ctrl_in = 2'b00; pop = 1'b1; step(d);
        v_flit_in = 1'b0; pop = 1'b0;
        n_chk++; if (occupancy !== 5'd1) $display("FAIL empty_pushpop_occ got %0d want 1", occupancy); else n_pass++;
        n_chk++; if (flit_out !== 16'h7777 || ctrl_out !== 2'b00 || msg_avail !== 1'b0)
            $display("FAIL empty_pushpop_head got %h/%b msg=%b want 7777/00 msg=0", flit_out, ctrl_out, msg_avail);
        else n_pass++;
        drain();
    endtask

    task automatic test_random_stress();
        bit pushed;
        int idx = 0;
        int bad = 0;
        logic [15:0] seq = 16'h9000;
        mq.delete();
        for (int cyc = 0; cyc < 10000; cyc++) begin
            // Generator holds the current flit until it is accepted.
            ctrl_in   = (idx == 0) ? 2'b01 : (idx == 8) ? 2'b11 : 2'b10;
            flit_in   = seq;
            v_flit_in = ($urandom_range(0, 99) < 60);
            pop       = ($urandom_range(0, 99) < 55);
            step(pushed);
            if (pushed) begin
                seq = seq + 16'd1;
                idx = (idx == 8) ? 0 : idx + 1;
            end
            n_chk++;
            if (occupancy !== 5'(mq.size()) || msg_avail !== (model_msgs() != 0) ||
                v_flit_out !== (mq.size() != 0) || rep_fifo_rdy !== (mq.size() != DEPTH)) begin
                if (bad < 10) $display("FAIL rand_state cyc %0d got occ=%0d msg=%b vld=%b rdy=%b want occ=%0d msgs=%0d",
                    cyc, occupancy, msg_avail, v_flit_out, rep_fifo_rdy, mq.size(), model_msgs());
                bad++;
            end else n_pass++;
            if (mq.size() != 0) begin
                n_chk++;
                if ({ctrl_out, flit_out} !== mq[0]) begin
                    if (bad < 10) $display("FAIL rand_head cyc %0d got %b/%h want %b/%h",
                        cyc, ctrl_out, flit_out, mq[0][17:16], mq[0][15:0]);
                    bad++;
                end else n_pass++;
            end
        end
        idle_inputs();
        drain();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single_msg();
        test_multi_flit();
        test_fill_wrap();
        test_simultaneous();
        test_random_stress();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
